// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the 16-bit CPU datapath. It accepts a memory
//   command with address and write data. It returns read data with a
//   one-cycle completion pulse after a programmable number of wait states.
//   It owns the data RAM and, optionally, the board I/O registers.
//
// Optional feature macro: MEM_MMIO_EN
//   When defined:
//     - A read of 9'h140 returns {8'b0, sw}.
//     - A write of 9'h100 loads led.
//   When undefined:
//     - sw is ignored and led is tied low.
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-high reset
//   mem_cmd    in   2   00 NONE, 01 READ, 10 WRITE, 11 illegal
//   mem_addr   in   AW  word address
//   mem_wdata  in   DW  write data
//   mdata      out  DW  registered read data, held until the next completed read
//   mem_ack    out  1   one-cycle completion pulse (high while in DONE)
//   busy       out  1   high whenever the FSM is not IDLE
//   mem_err    out  1   sticky error flag: illegal command or out-of-range access
//   sw         in   8   switch inputs (MMIO)
//   led        out  8   LED register (MMIO)
//   state_dbg  out  2   current FSM state (0 IDLE, 1 WAIT, 2 DONE)
//
// Handshake: a command is sampled only while busy is low. It completes with a
// single mem_ack cycle 1+WAIT cycles after the sampling edge. Inputs are
// ignored while busy is high, so the requester may change them freely then.
module mem_responder #(
  parameter int AW         = 9,
  parameter int DW         = 16,
  parameter int DEPTH      = 256,
  parameter int READ_WAIT  = 1,
  parameter int WRITE_WAIT = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    mem_cmd,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mdata,
  output logic          mem_ack,
  output logic          busy,
  output logic          mem_err,
  input  logic [7:0]    sw,
  output logic [7:0]    led,
  output logic [1:0]    state_dbg
);

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_ILL   = 2'b11;

  localparam int          IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W  = DEPTH[AW:0];
  localparam logic [3:0]  RW       = READ_WAIT[3:0];
  localparam logic [3:0]  WW       = WRITE_WAIT[3:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [3:0]    cnt_q, cnt_next;
  logic [1:0]    cmd_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          capture, illegal;

  logic [DW-1:0] ram [DEPTH];

  // Next-state logic.
  always_comb begin
    state_next = state;
    cnt_next   = cnt_q;
    capture    = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_IDLE: begin
        case (mem_cmd)
          CMD_READ: begin
            capture    = 1'b1;
            cnt_next   = RW;
            state_next = (RW == 4'd0) ? S_DONE : S_WAIT;
          end
          CMD_WRITE: begin
            capture    = 1'b1;
            cnt_next   = WW;
            state_next = (WW == 4'd0) ? S_DONE : S_WAIT;
          end
          CMD_ILL:  illegal = 1'b1;
          default:  state_next = S_IDLE;
        endcase
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          cnt_next   = 4'd0;
          state_next = S_DONE;
        end else begin
          cnt_next = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // With zero wait states the access commits on the sampling edge itself.
  // At that edge the captured registers are not loaded yet, so the live
  // inputs are used while IDLE.
  logic          in_idle;
  logic [1:0]    eff_cmd;
  logic [AW-1:0] eff_addr;
  logic [DW-1:0] eff_wdata;
  logic          commit, is_read, is_write;

  assign in_idle   = (state == S_IDLE);
  assign eff_cmd   = in_idle ? mem_cmd   : cmd_q;
  assign eff_addr  = in_idle ? mem_addr  : addr_q;
  assign eff_wdata = in_idle ? mem_wdata : wdata_q;
  assign commit    = (state_next == S_DONE) && (state != S_DONE);
  assign is_read   = (eff_cmd == CMD_READ);
  assign is_write  = (eff_cmd == CMD_WRITE);

  logic          mmio_addr, sw_hit, led_hit;
  logic [DW-1:0] mmio_rdata;

`ifdef MEM_MMIO_EN
  localparam logic [AW-1:0] ADDR_LED = AW'(9'h100);
  localparam logic [AW-1:0] ADDR_SW  = AW'(9'h140);

  logic [7:0] led_q;

  // The MMIO addresses never reach the RAM. A wrong-direction access to them
  // is handled like an out-of-range access.
  assign mmio_addr  = (eff_addr == ADDR_LED) || (eff_addr == ADDR_SW);
  assign sw_hit     = (eff_addr == ADDR_SW)  && is_read;
  assign led_hit    = (eff_addr == ADDR_LED) && is_write;
  assign mmio_rdata = {{(DW-8){1'b0}}, sw};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q <= 8'h00;
    end else if (commit && led_hit) begin
      led_q <= eff_wdata[7:0];
    end
  end

  assign led = led_q;
`else
  logic unused_sw;

  assign mmio_addr  = 1'b0;
  assign sw_hit     = 1'b0;
  assign led_hit    = 1'b0;
  assign mmio_rdata = '0;
  assign led        = 8'h00;
  assign unused_sw  = ^sw;
`endif

  logic          ram_ok, access_ok;
  logic [IW-1:0] ram_idx;
  logic [DW-1:0] rd_word;

  assign ram_ok    = ({1'b0, eff_addr} < DEPTH_W) && !mmio_addr;
  assign access_ok = ram_ok || sw_hit || led_hit;
  assign ram_idx   = eff_addr[IW-1:0];
  assign rd_word   = ram_ok ? ram[ram_idx] : (sw_hit ? mmio_rdata : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt_q   <= 4'd0;
      cmd_q   <= CMD_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      mdata   <= '0;
      mem_err <= 1'b0;
    end else begin
      state <= state_next;
      cnt_q <= cnt_next;
      if (capture) begin
        cmd_q   <= mem_cmd;
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end
      if (commit && is_read) mdata <= rd_word;
      if (illegal || (commit && !access_ok)) mem_err <= 1'b1;
    end
  end

  // The RAM has no reset. The reset gate keeps a command presented while
  // reset is held from committing a zero-wait write.
  always_ff @(posedge clk) begin
    if (!reset && commit && is_write && ram_ok) ram[ram_idx] <= eff_wdata;
  end

  assign mem_ack   = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule
